// File: rtl/shared_eva_burst_sequencer_pkg.sv
// shared_eva_burst_sequencer_pkg: shared constants, FSM state encoding and burst command layout
package shared_eva_burst_sequencer_pkg;
  localparam int eva_width_gp = 32;
  localparam int count_width_gp = 16;
  localparam int hash_width_gp = 4;
  localparam int epa_word_addr_width_gp = 16;
  localparam int shared_max_hash_gp = 3;
  typedef enum logic [1:0] {burst_idle, burst_run, burst_done} burst_state_e;
  typedef struct packed {
    logic [eva_width_gp-1:0] base;
    logic [eva_width_gp-1:0] stride;
    logic [count_width_gp-1:0] count;
    logic [hash_width_gp-1:0] hash;
  } burst_cmd_s;
endpackage

// File: rtl/shared_eva_burst_sequencer_hash.sv
// hash_function_shared: splits a shared EVA word index into tile X/Y and local word address for stripe hash 0..3
module hash_function_shared
  import shared_eva_burst_sequencer_pkg::*;
#(
  parameter int width_p = 32,
  parameter int x_cord_width_p = 6,
  parameter int y_cord_width_p = 5
)(
  input  logic [width_p-1:0] eva_i,
  input  logic [1:0] hash_i,
  output logic [x_cord_width_p-1:0] x_o,
  output logic [y_cord_width_p-1:0] y_o,
  output logic [epa_word_addr_width_gp-1:0] addr_o
);
  logic [width_p-1:0] sh;
  assign sh = eva_i >> hash_i;
  assign x_o = sh[x_cord_width_p-1:0];
  assign y_o = sh[x_cord_width_p+y_cord_width_p-1:x_cord_width_p];
  assign addr_o = epa_word_addr_width_gp'(((sh >> (x_cord_width_p + y_cord_width_p)) << hash_i) | (eva_i & ~({width_p{1'b1}} << hash_i)));
endmodule

// File: rtl/shared_eva_burst_sequencer.sv
// shared_eva_burst_sequencer: walks a strided shared-EVA burst, one hashed request per handshake; SHARED_EVA_BURST_SEQ_PERF_EN adds a stall counter
module shared_eva_burst_sequencer
  import shared_eva_burst_sequencer_pkg::*;
#(
  parameter int width_p = eva_width_gp,
  parameter int x_cord_width_p = 6,
  parameter int y_cord_width_p = 5,
  parameter int hash_width_p = hash_width_gp,
  parameter int count_width_p = count_width_gp
)(
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic cmd_v_i,
  output logic cmd_ready_o,
  input  logic [width_p-1:0] cmd_base_i,
  input  logic [width_p-1:0] cmd_stride_i,
  input  logic [count_width_p-1:0] cmd_count_i,
  input  logic [hash_width_p-1:0] cmd_hash_i,
  output logic req_v_o,
  input  logic req_yumi_i,
  output logic [x_cord_width_p-1:0] req_x_o,
  output logic [y_cord_width_p-1:0] req_y_o,
  output logic [epa_word_addr_width_gp-1:0] req_addr_o,
  output logic req_last_o,
  output logic done_v_o,
  output logic err_o,
  output logic [31:0] perf_stall_cnt_o
);
  localparam logic [1:0] idle_s = burst_idle;
  localparam logic [1:0] run_s = burst_run;
  localparam logic [1:0] done_s = burst_done;
  burst_cmd_s cmd;
  logic [1:0] state_r;
  logic [width_p-1:0] idx_r, stride_r;
  logic [count_width_p-1:0] rem_r;
  logic [1:0] hash_r;
  logic err_r, accept, illegal;
  assign cmd = '{base: cmd_base_i, stride: cmd_stride_i, count: cmd_count_i, hash: cmd_hash_i};
  assign cmd_ready_o = state_r == idle_s;
  assign req_v_o = state_r == run_s;
  assign req_last_o = req_v_o && rem_r == count_width_p'(1);
  assign done_v_o = state_r == done_s;
  assign err_o = done_v_o & err_r;
  assign accept = cmd_v_i & cmd_ready_o;
  assign illegal = cmd.hash > hash_width_p'(shared_max_hash_gp);
  // burst FSM: latch command, step index per yumi, pulse done for one cycle
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= idle_s;
      idx_r <= '0;
      stride_r <= '0;
      rem_r <= '0;
      hash_r <= '0;
      err_r <= 1'b0;
    end else if (accept) begin
      idx_r <= cmd.base;
      stride_r <= cmd.stride;
      rem_r <= cmd.count;
      hash_r <= cmd.hash[1:0];
      err_r <= illegal;
      state_r <= (illegal || cmd.count == '0) ? done_s : run_s;
    end else if (req_v_o && req_yumi_i) begin
      idx_r <= idx_r + stride_r;
      rem_r <= rem_r - count_width_p'(1);
      state_r <= req_last_o ? done_s : run_s;
    end else if (done_v_o) state_r <= idle_s;
  hash_function_shared #(
    .width_p(width_p),
    .x_cord_width_p(x_cord_width_p),
    .y_cord_width_p(y_cord_width_p)
  ) hash (
    .eva_i(idx_r),
    .hash_i(hash_r),
    .x_o(req_x_o),
    .y_o(req_y_o),
    .addr_o(req_addr_o)
  );
`ifdef SHARED_EVA_BURST_SEQ_PERF_EN
  logic [31:0] stall_r;
  // saturating count of cycles a request waits on the consumer
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) stall_r <= '0;
    else if (accept) stall_r <= '0;
    else if (req_v_o && !req_yumi_i && !(&stall_r)) stall_r <= stall_r + 32'd1;
  assign perf_stall_cnt_o = stall_r;
`else
  assign perf_stall_cnt_o = '0;
`endif
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) req_yumi_i |-> req_v_o);
endmodule

// File: tb/tb_shared_eva_burst_sequencer.sv
// tb_shared_eva_burst_sequencer: directed checks of burst sequencing, hashing, edge commands and reset abort
module tb_shared_eva_burst_sequencer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_v = 1'b0, cmd_ready, req_v, yumi = 1'b0, last, done, err;
  logic [31:0] base = '0, stride = '0, perf;
  logic [15:0] count = '0, addr;
  logic [3:0] hash = '0;
  logic [5:0] x;
  logic [4:0] y;
  int n = 0, fails = 0;
`ifdef SHARED_EVA_BURST_SEQ_PERF_EN
  localparam logic [31:0] stall_exp = 32'd5;
`else
  localparam logic [31:0] stall_exp = 32'd0;
`endif
  shared_eva_burst_sequencer dut (
    .clk_i(clk), .reset_n_i(reset_n), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready),
    .cmd_base_i(base), .cmd_stride_i(stride), .cmd_count_i(count), .cmd_hash_i(hash),
    .req_v_o(req_v), .req_yumi_i(yumi), .req_x_o(x), .req_y_o(y), .req_addr_o(addr),
    .req_last_o(last), .done_v_o(done), .err_o(err), .perf_stall_cnt_o(perf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic req(input string tag, input logic [5:0] ex, input logic [4:0] ey, input logic [15:0] ea, input logic el);
    chk({tag, ".v"}, req_v, 1);
    chk({tag, ".x"}, x, ex);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".addr"}, addr, ea);
    chk({tag, ".last"}, last, el);
  endtask
  task automatic send(input logic [31:0] b, input logic [31:0] s, input logic [15:0] c, input logic [3:0] h);
    cmd_v = 1'b1;
    base = b;
    stride = s;
    count = c;
    hash = h;
    chk("send.ready", cmd_ready, 1);
    @(negedge clk);
    cmd_v = 1'b0;
  endtask
  task automatic fin(input string tag, input logic e);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".err"}, err, e);
    chk({tag, ".reqv"}, req_v, 0);
    @(negedge clk);
    chk({tag, ".done_gone"}, done, 0);
    chk({tag, ".ready"}, cmd_ready, 1);
  endtask
  initial begin
    @(negedge clk);
    chk("rst.ready", cmd_ready, 1);
    chk("rst.reqv", req_v, 0);
    chk("rst.last", last, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.x", x, 0);
    chk("rst.y", y, 0);
    chk("rst.addr", addr, 0);
    chk("rst.perf", perf, 0);
    reset_n = 1'b1;
    @(negedge clk);
    send(32'h25, 1, 1, 0);
    req("single", 6'h25, 0, 0, 1);
    chk("single.done_early", done, 0);
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    fin("single", 0);
    send(32'h40, 1, 3, 1);
    req("multi0", 6'h20, 0, 0, 0);
    yumi = 1'b1;
    @(negedge clk);
    req("multi1", 6'h20, 0, 1, 0);
    @(negedge clk);
    req("multi2", 6'h21, 0, 0, 1);
    @(negedge clk);
    yumi = 1'b0;
    fin("multi", 0);
    send(32'h40, 1, 3, 1);
    for (int i = 0; i < 5; i++) begin
      req("stall", 6'h20, 0, 0, 0);
      @(negedge clk);
    end
    chk("stall.perf", perf, stall_exp);
    yumi = 1'b1;
    req("bp0", 6'h20, 0, 0, 0);
    @(negedge clk);
    req("bp1", 6'h20, 0, 1, 0);
    @(negedge clk);
    req("bp2", 6'h21, 0, 0, 1);
    @(negedge clk);
    yumi = 1'b0;
    chk("bp.perf_hold", perf, stall_exp);
    fin("bp", 0);
    send(32'h10, 1, 0, 0);
    chk("cnt0.perf_clr", perf, 0);
    fin("cnt0", 0);
    send(32'h10, 1, 4, 5);
    fin("hash5", 1);
    send(32'hFFFF_FFFF, 1, 2, 0);
    req("wrap0", 6'h3f, 5'h1f, 16'hFFFF, 0);
    yumi = 1'b1;
    @(negedge clk);
    req("wrap1", 0, 0, 0, 1);
    @(negedge clk);
    yumi = 1'b0;
    fin("wrap", 0);
    send(32'h100, 1, 4, 0);
    yumi = 1'b1;
    @(negedge clk);
    req("abort1", 6'h01, 5'h04, 0, 0);
    yumi = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort.reqv", req_v, 0);
    chk("abort.ready", cmd_ready, 1);
    chk("abort.x", x, 0);
    chk("abort.y", y, 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort.done", done, 0);
    chk("abort.ready_rel", cmd_ready, 1);
    @(negedge clk);
    chk("abort.done_late", done, 0);
    send(32'h25, 1, 1, 2);
    req("after", 6'h09, 0, 1, 1);
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    fin("after", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/shared_eva_burst_sequencer.md
Name: shared_eva_burst_sequencer

Overview:
- Sequences a burst of tile-group shared-array accesses.
- Accepts a command {base shared index, element count, stride, stripe hash}. Walks the indices base, base+stride, and so on, one per handshake.
- For each index, emits the destination tile X/Y and the local word address by instancing the existing shared-EVA hash datapath.
- Sits between a vector or DMA-style front end and the vanilla core's remote-request path.

Parameters:
- width_p, 32, width of the shared EVA word index.
- x_cord_width_p, 6, tile X coordinate width.
- y_cord_width_p, 5, tile Y coordinate width.
- hash_width_p, 4, stripe hash field width.
- count_width_p, 16, element count width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  sequencer can accept a command.
- cmd_base_i  in  width_p  first shared index.
- cmd_stride_i  in  width_p  index increment per element.
- cmd_count_i  in  count_width_p  number of elements.
- cmd_hash_i  in  hash_width_p  stripe hash; legal values 0..3.
- req_v_o  out  1  request valid.
- req_yumi_i  in  1  consumer takes the request; legal only when req_v_o=1.
- req_x_o  out  x_cord_width_p  destination X.
- req_y_o  out  y_cord_width_p  destination Y.
- req_addr_o  out  epa_word_addr_width_gp  local word address.
- req_last_o  out  1  current request is the final element.
- done_v_o  out  1  one-cycle burst-complete pulse.
- err_o  out  1  one-cycle pulse, coincident with done_v_o, when the hash is illegal.
- perf_stall_cnt_o  out  32  stall counter; see Optional Feature.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (reset_n_i). All state clears immediately when reset_n_i=0.
- Reset values: state=IDLE, cmd_ready_o=1, req_v_o=0, req_last_o=0, done_v_o=0, err_o=0. Index, remaining count, stride and hash registers are 0, so req_x_o, req_y_o and req_addr_o read 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready_o=1; a command is accepted on cmd_v_i & cmd_ready_o.
  - On accept: latch base into idx_r, and latch stride, hash and count.
  - If count=0 or hash>3: go to DONE. err flag is set iff hash>3.
  - Otherwise go to RUN.
- RUN:
  - cmd_ready_o=0, req_v_o=1.
  - Outputs are combinational from idx_r and hash_r through the hash sub-module, so they are stable while req_v_o=1 and req_yumi_i=0.
  - req_last_o = (remaining_r==1).
  - On req_yumi_i: idx_r <= idx_r + stride_r (modulo 2^width_p; wrap silently) and remaining_r decrements.
  - If the yumi arrives while req_last_o=1: go to DONE.
- DONE:
  - done_v_o=1 for exactly one cycle; err_o=1 in the same cycle if the err flag is set.
  - Then return to IDLE. req_v_o=0 in DONE.
- Latency:
  - Command accepted in cycle N: first req_v_o in cycle N+1.
  - With yumi asserted continuously: one request per cycle. Final yumi in cycle M: done_v_o in cycle M+1. Next command can be accepted in cycle M+2.
  - count=0 or illegal hash: done_v_o in cycle N+1.
- Hash mapping (s = hash, 0..3):
  - X = idx[x_w+s-1 : s].
  - Y = the next y_w bits above X.
  - addr = {the bits above Y, idx[s-1:0]}, zero-extended or truncated to epa_word_addr_width_gp.
- Command rules: cmd_v_i is ignored outside IDLE; there is no queuing. req_yumi_i while req_v_o=0 is an assertion error in simulation.
- Reset mid-burst aborts the burst: no done_v_o is issued, and outputs return to their reset values asynchronously.

Optional Feature:
- Macro: SHARED_EVA_BURST_SEQ_PERF_EN.
- When defined: a 32-bit saturating counter increments every cycle with req_v_o & ~req_yumi_i. It is cleared by reset and by each command accept, and drives perf_stall_cnt_o.
- When undefined: there is no counter logic, and perf_stall_cnt_o is tied to 0.

Decomposition:
- Package additions to bsg_manycore_pkg:
  - shared_max_hash_gp = 3.
  - An enum typedef for the FSM states {IDLE, RUN, DONE}.
  - A packed struct typedef for the burst command {base, stride, count, hash}.
- Sub-module: instance the existing hash_function_shared combinationally on idx_r and hash_r. No new sub-module.

Test Plan:
- Directed single-element burst: base=0x25, stride=1, count=1, hash=0, x_w=6, y_w=5, yumi held 1 -> req_v_o in cycle N+1 with x=0x25, y=0, addr=0, req_last_o=1; done_v_o in N+2; err_o=0.
- Directed multi-element burst: base=0x40, stride=1, count=3, hash=1 -> three requests with (x,y,addr) = (0x20,0,0), (0x20,0,1), (0x21,0,0); req_last_o only on the third; done_v_o after the third yumi.
- Backpressure: same command with yumi low for 5 cycles on the first request -> outputs held constant; the perf counter reads 5 when SHARED_EVA_BURST_SEQ_PERF_EN is defined and 0 when it is not.
- Edge commands:
  - count=0 -> no req_v_o; done_v_o=1, err_o=0 one cycle after accept.
  - hash=5 -> no req_v_o; done_v_o=1 and err_o=1 together.
- Wrap-around: base=0xFFFFFFFF, stride=1, count=2, hash=0 -> second index is 0, giving x=0, y=0, addr=0; no error.
- Reset mid-operation: deassert reset_n_i during the 2nd of 4 requests -> req_v_o=0 immediately, no done_v_o, cmd_ready_o=1 after release; a new command then runs normally.
